// File: rtl/window_3x3_gen_pkg.sv
// Shared image-pipeline package.
// Holds the default pixel width and frame geometry used by the 3x3 window
// generator and the downstream 3x3 stages, plus the window index order:
//   p0 p1 p2   top row, left to right
//   p3 p4 p5   middle row
//   p6 p7 p8   bottom row (p8 is the newest pixel)
package window_3x3_gen_pkg;

    localparam int IMGP_DW    = 8;
    localparam int IMGP_IMG_W = 16;
    localparam int IMGP_IMG_H = 16;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;
    localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

    typedef enum int unsigned {
        WIN_P0 = 0, WIN_P1 = 1, WIN_P2 = 2,
        WIN_P3 = 3, WIN_P4 = 4, WIN_P5 = 5,
        WIN_P6 = 6, WIN_P7 = 7, WIN_P8 = 8
    } win_idx_e;

    // Flat window index from (row, col) inside the 3x3 window.
    function automatic int win_idx(input int row, input int col);
        return row * WIN_COLS + col;
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// line_buffer: one stored image line, DEPTH x DW.
// Ports:
//   clk  - clock
//   we   - write enable; din is written at addr on the rising edge
//   addr - read/write address
//   din  - write data
//   dout - contents at addr; reads the value held before this edge's write
//          (read-before-write), so the window shift sees the old line data.
// The read is asynchronous so the window generator keeps its one-clock
// latency with the address taken straight from the column counter.
module line_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    // Line storage is intentionally not reset: the window generator masks
    // the first two rows of each frame, so stale contents never escape.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
    end

    assign dout = r_mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: sliding 3x3 window generator for a raster pixel stream.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   pix_in         - raster-order pixel, accepted when pix_valid is high
//   pix_valid      - pixel accept strobe
//   sof            - start of frame; marks the accepted (or next) pixel as (0,0)
//   p0..p8         - 3x3 window, top-left p0 to bottom-right p8 (newest)
//   win_valid      - p0..p8 hold a complete in-image window
//   frame_done     - one-cycle pulse after the last pixel of a frame
// All outputs are registered; the window appears one clock after acceptance.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int DW    = IMGP_DW,
    parameter int IMG_W = IMGP_IMG_W,
    parameter int IMG_H = IMGP_IMG_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] p0,
    output logic [DW-1:0] p1,
    output logic [DW-1:0] p2,
    output logic [DW-1:0] p3,
    output logic [DW-1:0] p4,
    output logic [DW-1:0] p5,
    output logic [DW-1:0] p6,
    output logic [DW-1:0] p7,
    output logic [DW-1:0] p8,
    output logic          win_valid,
    output logic          frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_win_valid;
    logic          r_frame_done;

    // Position of the pixel on the bus this cycle: sof forces it to (0,0)
    // even mid-frame, which abandons whatever partial frame was in flight.
    logic [CW-1:0] w_col_eff;
    logic [RW-1:0] w_row_eff;
    logic          w_col_last;
    logic          w_row_last;

    assign w_col_eff  = sof ? '0 : r_col;
    assign w_row_eff  = sof ? '0 : r_row;
    assign w_col_last = (w_col_eff == COL_LAST);
    assign w_row_last = (w_row_eff == ROW_LAST);

    // lb0 holds the previous line, lb1 the line before it. lb1 is refilled
    // from lb0's old value at the same column, so the two shift down together.
    logic [DW-1:0] w_lb0_q;
    logic [DW-1:0] w_lb1_q;

    line_buffer #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk  (clk),
        .we   (pix_valid),
        .addr (w_col_eff),
        .din  (pix_in),
        .dout (w_lb0_q)
    );

    line_buffer #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk  (clk),
        .we   (pix_valid),
        .addr (w_col_eff),
        .din  (w_lb0_q),
        .dout (w_lb1_q)
    );

    // New column entering each window row: oldest line on top.
    logic [DW-1:0] w_tap [WIN_ROWS];
    assign w_tap[0] = w_lb1_q;
    assign w_tap[1] = w_lb0_q;
    assign w_tap[2] = pix_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIN_ROWS; gi++) begin : g_row
            logic [DW-1:0] r_tap [WIN_COLS];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tap[0] <= '0;
                    r_tap[1] <= '0;
                    r_tap[2] <= '0;
                end else if (pix_valid) begin
                    r_tap[0] <= r_tap[1];
                    r_tap[1] <= r_tap[2];
                    r_tap[2] <= w_tap[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (pix_valid) begin
                // Column >= 2 keeps windows from straddling a line boundary;
                // row >= 2 keeps stale line memory out of the window.
                r_win_valid  <= (w_row_eff >= RW'(2)) && (w_col_eff >= CW'(2));
                r_frame_done <= w_row_last && w_col_last;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : (w_row_eff + RW'(1));
                end else begin
                    r_col <= w_col_eff + CW'(1);
                    r_row <= w_row_eff;
                end
            end else if (sof) begin
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

    assign p0 = g_row[0].r_tap[0];
    assign p1 = g_row[0].r_tap[1];
    assign p2 = g_row[0].r_tap[2];
    assign p3 = g_row[1].r_tap[0];
    assign p4 = g_row[1].r_tap[1];
    assign p5 = g_row[1].r_tap[2];
    assign p6 = g_row[2].r_tap[0];
    assign p7 = g_row[2].r_tap[1];
    assign p8 = g_row[2].r_tap[2];

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam int DW    = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic          win_valid;
    logic          frame_done;

    window_3x3_gen #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pix;
        logic        exp_wv;
        logic        exp_fd;
        logic [71:0] exp_win;
    } vec_t;

    vec_t        tbl [NPIX];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [71:0] first_win;
    logic [71:0] last_win;

    function automatic logic [71:0] cur_win();
        return {p0, p1, p2, p3, p4, p5, p6, p7, p8};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One pixel, sampled 1 ns after the accepting edge.
    task automatic send(input logic [7:0] pix, input logic with_sof);
        @(negedge clk);
        pix_in    = pix;
        pix_valid = 1'b1;
        sof       = with_sof;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_wv", {71'd0, win_valid}, 72'd0);
            chk("idle_fd", {71'd0, frame_done}, 72'd0);
        end
    endtask

    task automatic send_prefix(input int n);
        for (int k = 0; k < n; k++) begin
            send(tbl[k].pix, 1'b0);
            chk($sformatf("pre_wv[%h]", tbl[k].pix), {71'd0, win_valid}, {71'd0, tbl[k].exp_wv});
            chk($sformatf("pre_fd[%h]", tbl[k].pix), {71'd0, frame_done}, {71'd0, tbl[k].exp_fd});
        end
    endtask

    task automatic run_frame(input string tag, input logic with_sof, input int max_gap);
        int wv_cnt = 0;
        int fd_cnt = 0;
        for (int k = 0; k < NPIX; k++) begin
            send(tbl[k].pix, with_sof && (k == 0));
            chk($sformatf("%s_wv[%h]", tag, tbl[k].pix), {71'd0, win_valid}, {71'd0, tbl[k].exp_wv});
            chk($sformatf("%s_fd[%h]", tag, tbl[k].pix), {71'd0, frame_done}, {71'd0, tbl[k].exp_fd});
            if (tbl[k].exp_wv) begin
                chk($sformatf("%s_win[%h]", tag, tbl[k].pix), cur_win(), tbl[k].exp_win);
            end
            if (win_valid) begin
                if (wv_cnt == 0) first_win = cur_win();
                last_win = cur_win();
                wv_cnt++;
            end
            if (frame_done) fd_cnt++;
            if (max_gap > 0 && k < NPIX - 1) idle($urandom_range(1, max_gap));
        end
        chk({tag, "_wv_count"}, 72'(wv_cnt), 72'd4);
        chk({tag, "_fd_count"}, 72'(fd_cnt), 72'd1);
        chk({tag, "_first"}, first_win, 72'h00_01_02_10_11_12_20_21_22);
        chk({tag, "_last"},  last_win,  72'h11_12_13_21_22_23_31_32_33);
    endtask

    initial begin
        // Expected stream: pixel = 16*row+col; window for (r,c) is rows r-2..r,
        // cols c-2..c, top-left first.
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                logic [71:0] w;
                w = '0;
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            w = (w << 8) | 72'(16 * (r - 2 + i) + (c - 2 + j));
                end
                tbl[r * IMG_W + c].pix     = 8'(16 * r + c);
                tbl[r * IMG_W + c].exp_wv  = (r >= 2 && c >= 2);
                tbl[r * IMG_W + c].exp_fd  = (r == IMG_H - 1 && c == IMG_W - 1);
                tbl[r * IMG_W + c].exp_win = w;
            end
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_win", cur_win(), 72'd0);
        chk("reset_wv",  {71'd0, win_valid}, 72'd0);
        chk("reset_fd",  {71'd0, frame_done}, 72'd0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame, then a back-to-back repeat
        run_frame("cont", 1'b0, 0);
        run_frame("b2b", 1'b0, 0);

        // Gapped frame: idle cycles must show win_valid=0
        run_frame("gap", 1'b0, 5);

        // Asynchronous reset after 0x13, checked before any clock edge
        send_prefix(8);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_win", cur_win(), 72'd0);
        chk("arst_wv",  {71'd0, win_valid}, 72'd0);
        chk("arst_fd",  {71'd0, frame_done}, 72'd0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_rst", 1'b0, 0);

        // sof with pixel 0x00 after 0x21 abandons the partial frame
        send_prefix(10);
        run_frame("sof_pix", 1'b1, 0);

        // sof without pix_valid resets position
        send_prefix(6);
        @(negedge clk);
        sof = 1'b1;
        @(posedge clk);
        #1;
        sof = 1'b0;
        chk("sof_only_wv", {71'd0, win_valid}, 72'd0);
        run_frame("sof_only", 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter DW, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 16: pixels per line, minimum 3.
REQ-003 SHALL have parameter IMG_H, default 16: lines per frame, minimum 3.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pix_in, input, DW bits: raster-order pixel.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in is accepted on this edge.
REQ-008 SHALL have port sof, input, 1 bit: start of frame; the pixel accepted with it, or the next pixel accepted, is row 0, col 0.
REQ-009 SHALL have ports p0..p8, output, DW bits each: 3x3 window.
  - p0 p1 p2: top row, left to right.
  - p3 p4 p5: middle row, left to right.
  - p6 p7 p8: bottom row, left to right; p8 is the newest pixel.
REQ-010 SHALL have port win_valid, output, 1 bit: p0..p8 hold a complete in-image window.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1) giving the position of the next accepted pixel.
REQ-013 SHALL hold two line memories, each IMG_W x DW: lb0 holds the previous line and lb1 holds the line before it.
REQ-014 On each accepted pixel at position col, SHALL perform all of the following in one edge:
  - p0<=p1, p1<=p2, p2<=lb1[col];
  - p3<=p4, p4<=p5, p5<=lb0[col];
  - p6<=p7, p7<=p8, p8<=pix_in;
  - lb1[col]<=lb0[col], lb0[col]<=pix_in.
REQ-015 SHALL assert win_valid in the cycle after acceptance if and only if the accepted pixel had row>=2 and col>=2; windows never straddle a line boundary.
REQ-016 Latency SHALL be exactly 1 clock from the accepting edge to the window on p0..p8.
REQ-017 With pix_valid=0, SHALL hold p0..p8, line memories and counters unchanged, and drive win_valid=0; arbitrary gaps are allowed.
REQ-018 Counter wrap SHALL work as follows:
  - col at IMG_W-1 SHALL wrap to 0 and increment row;
  - at row IMG_H-1, col IMG_W-1, both counters SHALL return to 0 and frame_done SHALL pulse for 1 cycle.
REQ-019 sof with pix_valid SHALL treat the pixel as row 0, col 0; the counters then become row 0, col 1.
REQ-020 sof without pix_valid SHALL set row=0 and col=0 on that edge.
REQ-021 sof mid-frame SHALL abandon the partial frame: no frame_done for it, and win_valid is suppressed until the new frame reaches row 2, col 2.
REQ-022 Each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) win_valid pulses.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst SHALL asynchronously clear p0..p8, win_valid, frame_done, row and col to 0.
REQ-025 Line memories SHALL NOT be reset; row<2 masking guarantees their stale contents never reach a valid window.
REQ-026 After rst deasserts, the first accepted pixel SHALL be row 0, col 0.
REQ-027 rst mid-frame SHALL behave as a fresh power-up.

Structure
REQ-028 Default DW, IMG_W and IMG_H and the window index order SHALL live in the shared image-pipeline package, also used by the downstream 3x3 threshold stage.
REQ-029 SHALL instantiate sub-module line_buffer twice (one per stored line).
  - Ports: clk, we, addr, din, dout.
  - Read-before-write at the same address in the same cycle.
REQ-030 p0..p8 SHALL connect one-to-one to the same-named inputs of the downstream convolution stage.

Verification (IMG_W=4, IMG_H=4; pixel value = 16*row+col)
REQ-031 Continuous frame after reset:
  - first win_valid SHALL follow acceptance of 0x22;
  - window SHALL be p0..p8 = 00,01,02,10,11,12,20,21,22;
  - exactly 4 win_valid pulses SHALL occur;
  - last window SHALL be 11,12,13,21,22,23,31,32,33.
REQ-032 Random pix_valid gaps (1-5 idle cycles) over the same frame SHALL produce identical window sequence and count, with win_valid=0 in every idle cycle.
REQ-033 frame_done SHALL pulse once, in the cycle after 0x33 is accepted; a second back-to-back frame SHALL repeat REQ-031 exactly.
REQ-034 rst asserted after pixel 0x13:
  - outputs SHALL read 0 immediately;
  - the restarted frame SHALL give 4 windows with no stale data.
REQ-035 sof with pixel 0x00 injected after pixel 0x21:
  - no frame_done for the abandoned frame;
  - next win_valid SHALL occur only after the new frame's 0x22.
REQ-036 Line-boundary check: no win_valid SHALL occur after acceptance of any col-0 or col-1 pixel (e.g. 0x30, 0x31).
